// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: control, FIFO read port and serial outputs of fifo_uart_tx
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
);
  logic                  tx_en;
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_ren;
  logic                  txd;
  logic                  tx_busy;
  logic                  tx_done;
  modport master (
    input  tx_en, baud_div, fifo_empty, fifo_rdata,
    output fifo_ren, txd, tx_busy, tx_done
  );
  modport slave (
    output tx_en, baud_div, fifo_empty, fifo_rdata,
    input  fifo_ren, txd, tx_busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter fed from a sync FIFO; define FIFO_UART_TX_PARITY_EN to add an even parity bit
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
  localparam state_t POST_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
  localparam state_t POST_DATA = STOP;
`endif
  state_t                r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_div, r_cnt;
  logic [BW-1:0]         r_bits;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_txd, w_txd_nxt, w_ren, w_fetch, w_bit_end, w_last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_par;
`endif
  // a fetch is only allowed outside reset, when enabled and the FIFO has data
  assign w_fetch    = !rst && bus.tx_en && !bus.fifo_empty;
  assign w_bit_end  = r_cnt == '0;
  assign w_last_bit = r_bits == BW'(DATA_WIDTH - 1);
  assign bus.fifo_ren = w_ren;
  assign bus.txd      = r_txd;
  assign bus.tx_busy  = r_state != IDLE;
  assign bus.tx_done  = r_state == STOP && w_bit_end;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end
  // next state, FIFO strobe, next shift value and the txd level of the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    w_shift_nxt = r_shift;
    case (r_state)
      IDLE: begin
        w_ren       = w_fetch;
        w_state_nxt = w_fetch ? FETCH : IDLE;
      end
      FETCH: begin
        w_shift_nxt = bus.fifo_rdata;
        w_state_nxt = START;
      end
      START: w_state_nxt = w_bit_end ? DATA : START;
      DATA: begin
        w_shift_nxt = (w_bit_end && !w_last_bit) ? r_shift >> 1 : r_shift;
        w_state_nxt = (w_bit_end && w_last_bit) ? POST_DATA : DATA;
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: w_state_nxt = w_bit_end ? STOP : PARITY;
`endif
      STOP: begin
        w_ren       = w_bit_end && w_fetch;
        w_state_nxt = w_bit_end ? (w_fetch ? FETCH : IDLE) : STOP;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_txd_nxt = (w_state_nxt == DATA) ? w_shift_nxt[0] : (w_state_nxt != START);
`ifdef FIFO_UART_TX_PARITY_EN
    if (w_state_nxt == PARITY) w_txd_nxt = r_par;
`endif
  end
  // datapath: registered txd, shift register, bit timer and data bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txd   <= 1'b1;
      r_shift <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_bits  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_txd   <= w_txd_nxt;
      r_shift <= w_shift_nxt;
      if (r_state == FETCH) begin
        r_div  <= bus.baud_div;
        r_cnt  <= bus.baud_div;
        r_bits <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
        r_par  <= ^bus.fifo_rdata;
`endif
      end else if (r_state != IDLE) begin
        r_cnt <= w_bit_end ? r_div : r_cnt - 1'b1;
        if (r_state == DATA && w_bit_end) r_bits <= r_bits + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench comparing captured serial frames against a bit-level frame model
module tb_fifo_uart_tx;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fifo_uart_tx_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) bus ();
  fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // FIFO model: stimulus writes mem/wr, the read side advances rd on fifo_ren
  logic [7:0] mem [0:1023];
  int wr = 0;
  int rd = 0;
  assign bus.fifo_empty = (rd == wr);
  always @(posedge clk) begin
    if (bus.fifo_ren) begin
      bus.fifo_rdata <= mem[rd];
      rd <= rd + 1;
    end
  end

  function automatic int exp_len(input int div);
    return (10 + PAR) * (div + 1);
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int div, input int k);
    int b;
    b = k / (div + 1);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // monitor: counts events, captures each frame from the falling start edge to tx_done, checks it
  int cyc = 0, ren_cnt = 0, busy_cnt = 0, low_cnt = 0, done_cnt = 0;
  int last_ren = -100, last_done = -100;
  bit in_frame = 0;
  bit cap[$];
  int gaps[$];
  always @(negedge clk) begin
    exp_t e;
    int nbad;
    cyc++;
    if (rst) begin
      in_frame = 0;
      cap.delete();
    end else begin
      if (bus.fifo_ren) begin
        ren_cnt++;
        last_ren = cyc;
        chk("ren_while_empty", int'(bus.fifo_empty), 0);
      end
      if (bus.tx_busy) busy_cnt++;
      if (!bus.txd) low_cnt++;
      if (bus.tx_done) done_cnt++;
      if (!in_frame && !bus.txd) begin
        in_frame = 1;
        cap.delete();
        gaps.push_back(cyc - last_done);
        chk("ren_to_start", cyc - last_ren, 2);
      end
      if (in_frame) cap.push_back(bus.txd);
      if (bus.tx_done) begin
        if (!in_frame || exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got tx_done at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          nbad = 0;
          for (int k = 0; k < cap.size(); k++)
            if (cap[k] !== exp_bit(e.data, e.div, k)) nbad++;
          chk("frame_len", cap.size(), exp_len(e.div));
          checks++;
          if (nbad != 0) begin
            failures++;
            $display("FAIL frame_bits: byte 0x%02h div %0d got %0d wrong cycles, want 0", e.data, e.div, nbad);
          end
        end
        in_frame = 0;
        last_done = cyc;
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit to_fifo, input bit expect_tx);
    if (to_fifo) begin
      mem[wr] = d;
      wr++;
    end
    if (expect_tx) exp_q.push_back('{d, int'(bus.baud_div)});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.tx_busy) && n < 5000);
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s_timeout: got %0d frames pending, want 0", name, exp_q.size());
    end
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.txd && n < 1000);
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL %s_start_timeout: got txd=1 for %0d cycles, want a start bit", name, n);
    end
  endtask

  initial begin
    int r0, b0, d0, l0, g0, n;
    rst = 1'b1;
    bus.tx_en = 1'b1;
    bus.baud_div = 16'd3;
    push(8'h3C, 1, 1);
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(bus.txd), 1);
    chk("rst_ren", int'(bus.fifo_ren), 0);
    chk("rst_busy", int'(bus.tx_busy), 0);
    chk("rst_done", int'(bus.tx_done), 0);
    rst = 1'b0;
    wait_idle("post_reset");
    // single 0xA5 frame at baud_div=3
    r0 = ren_cnt; b0 = busy_cnt; d0 = done_cnt;
    push(8'hA5, 1, 1);
    wait_idle("a5");
    chk("a5_ren", ren_cnt - r0, 1);
    chk("a5_done", done_cnt - d0, 1);
    chk("a5_busy", busy_cnt - b0, exp_len(3) + 1);
    // three back-to-back frames at baud_div=0
    bus.baud_div = 16'd0;
    r0 = ren_cnt; g0 = gaps.size();
    push(8'h00, 1, 1);
    push(8'hFF, 1, 1);
    push(8'h55, 1, 1);
    wait_idle("b2b");
    chk("b2b_ren", ren_cnt - r0, 3);
    chk("b2b_frames", gaps.size() - g0, 3);
    if (gaps.size() >= g0 + 3) begin
      chk("b2b_gap1", gaps[g0+1], 2);
      chk("b2b_gap2", gaps[g0+2], 2);
    end
    // empty FIFO with tx_en high: nothing happens
    r0 = ren_cnt; b0 = busy_cnt; l0 = low_cnt;
    repeat (100) @(negedge clk);
    chk("empty_ren", ren_cnt - r0, 0);
    chk("empty_busy", busy_cnt - b0, 0);
    chk("empty_txd_low", low_cnt - l0, 0);
    // divisor changed mid-frame is ignored until the next fetch
    bus.baud_div = 16'd2;
    push(8'h96, 1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_busy && n < 100);
    chk("div_busy_seen", int'(bus.tx_busy), 1);
    repeat (2) @(negedge clk);
    bus.baud_div = 16'($urandom_range(5, 9));
    wait_idle("div_change");
    // tx_en dropped during DATA of the first of two bytes
    bus.baud_div = 16'd3;
    r0 = ren_cnt;
    push(8'h3A, 1, 1);
    push(8'hC5, 1, 0);
    wait_start("txen_drop");
    repeat (20) @(negedge clk);
    bus.tx_en = 1'b0;
    wait_idle("txen_drop");
    repeat (20) @(negedge clk);
    chk("txen_drop_ren", ren_cnt - r0, 1);
    chk("txen_drop_fifo_left", wr - rd, 1);
    chk("txen_drop_idle", int'(bus.tx_busy), 0);
    push(8'hC5, 0, 1);
    bus.tx_en = 1'b1;
    wait_idle("txen_resume");
    // reset pulsed during data bit 3; partial byte dropped, next byte sent cleanly
    push(8'hE1, 1, 0);
    push(8'h4B, 1, 1);
    wait_start("rst_mid");
    repeat (17) @(negedge clk);
    d0 = done_cnt; r0 = ren_cnt;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_txd", int'(bus.txd), 1);
    chk("rst_mid_busy", int'(bus.tx_busy), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_done", done_cnt - d0, 0);
    chk("rst_mid_ren", ren_cnt - r0, 0);
    rst = 1'b0;
    wait_idle("rst_restart");
    chk("rst_restart_ren", ren_cnt - r0, 1);
    chk("rst_restart_done", done_cnt - d0, 1);
    // 0x07 at baud_div=1 (parity bit 1 when enabled)
    bus.baud_div = 16'd1;
    push(8'h07, 1, 1);
    wait_idle("b07");
    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      bus.baud_div = 16'($urandom_range(0, 4));
      r0 = ren_cnt;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) push(8'($urandom), 1, 1);
      wait_idle("rand");
      chk("rand_ren", ren_cnt - r0, n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per character.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_en  input  1  permits fetching new characters from the FIFO.
REQ-006 SHALL have port baud_div  input  DIV_WIDTH  bit period equals baud_div+1 clk cycles.
REQ-007 SHALL have port fifo_empty  input  1  FIFO empty flag from the sync FIFO read side.
REQ-008 SHALL have port fifo_rdata  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_ren.
REQ-009 SHALL have port fifo_ren  output  1  FIFO read strobe, one cycle per character.
REQ-010 SHALL have port txd  output  1  serial line, idle high, registered.
REQ-011 SHALL have port tx_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-013 SHALL implement states IDLE, FETCH, START, DATA, PARITY (macro only), STOP.
REQ-014 SHALL, in IDLE with tx_en=1 and fifo_empty=0, assert fifo_ren for that cycle and move to FETCH.
REQ-015 SHALL never assert fifo_ren while fifo_empty=1; at most one fifo_ren per frame.
REQ-016 SHALL, in FETCH (exactly 1 cycle), capture fifo_rdata into the shift register, latch baud_div, and move to START.
REQ-017 SHALL ignore baud_div changes until the next FETCH.
REQ-018 SHALL drive txd=0 for one bit period in START, then DATA_WIDTH data bits LSB first, then txd=1 for one bit period in STOP.
REQ-019 SHALL time each bit with a down-counter loaded with the latched divisor; baud_div=0 gives 1-cycle bits.
REQ-020 SHALL count data bits with a counter of width ceil(log2(DATA_WIDTH))+1 with no wrap inside a frame.
REQ-021 SHALL drive txd low on the first clock edge after the FETCH cycle, i.e., 2 cycles after the fifo_ren cycle.
REQ-022 SHALL, at the end of STOP, assert fifo_ren and move directly to FETCH if tx_en=1 and fifo_empty=0; otherwise go to IDLE.
REQ-023 SHALL hold txd=1 in IDLE and FETCH, so back-to-back frames are separated by exactly one idle cycle.
REQ-024 SHALL finish a frame in progress when tx_en falls mid-frame, then perform no further fetch.
REQ-025 SHALL have a frame length of (DATA_WIDTH+2)*(baud_div+1) cycles, plus (baud_div+1) with parity.

Reset
REQ-026 SHALL, while rst=1 (including mid-frame), force txd=1, fifo_ren=0, tx_busy=0, tx_done=0, state IDLE, and clear counters.
REQ-027 SHALL discard a partially sent character on reset; no fetch is issued in the first cycle after rst falls unless the REQ-014 conditions hold.

Configuration
REQ-028 SHALL, with macro FIFO_UART_TX_PARITY_EN defined, insert PARITY after DATA, sending the XOR of the data bits (even parity) for one bit period.
REQ-029 SHALL, without FIFO_UART_TX_PARITY_EN, omit the PARITY state and go DATA -> STOP.

Verification
REQ-030 SHALL cover: baud_div=3, FIFO holds 0xA5, tx_en=1 -> one fifo_ren; txd bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; one tx_done pulse; tx_busy high 41 cycles.
REQ-031 SHALL cover: baud_div=0, FIFO holds 0x00,0xFF,0x55 -> three 10-cycle frames separated by one txd=1 cycle; exactly 3 fifo_ren pulses.
REQ-032 SHALL cover: fifo_empty=1, tx_en=1 for 100 cycles -> fifo_ren=0, txd=1, tx_busy=0 throughout.
REQ-033 SHALL cover: 2 bytes queued, tx_en dropped during DATA of the first byte -> first frame completes; no second fifo_ren; return to IDLE.
REQ-034 SHALL cover: rst pulsed during DATA bit 3 -> txd=1 and tx_busy=0 immediately; no tx_done; restart after rst falls sends the next FIFO byte cleanly.
REQ-035 SHALL cover: macro defined, byte 0x07, baud_div=1 -> 11-bit frame, parity bit 1, tx_done 22 cycles after txd falls.
